uart_tx_ctrl: RTL
=================

# uart_tx_ctrl

Sequencing controller for the console UART resource. It accepts the core's 9-bit console write strobe (`uart_out`: bit 8 = write, bits 7:0 = byte) with no backpressure and buffers bytes in a FIFO. It serialises each byte as an 8N1 frame on a physical `tx` line and reports each completed byte as a one-cycle `{done_valid, done_data}` pulse, so the simulation UART printer and real hardware see identical byte streams. It sits between `RV32IM` and the board pin / console model.

## Interface
- `CLKS_PER_BIT`, 4, clock cycles per serial bit (≥2).
- `DEPTH`, 16, FIFO entries (power of 2, ≥2).
- `AW`, 4, log2(`DEPTH`).
- `clock`  in  1  system clock, rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `uart_in`  in  9  bit 8 = write strobe (one byte per high cycle); bits 7:0 = data.
- `tx`  out  1  serial line; idle high.
- `busy`  out  1  high when FSM ≠ IDLE or FIFO non-empty.
- `overflow`  out  1  sticky; a write was dropped. Cleared only by reset.
- `fifo_count`  out  AW+1  current FIFO occupancy, 0..`DEPTH`.
- `done_valid`  out  1  one-cycle pulse at frame completion.
- `done_data`  out  8  byte just completed; valid while `done_valid`=1.

## Operation
- Reset values: `tx`=1, `busy`=0, `overflow`=0, `fifo_count`=0, `done_valid`=0, `done_data`=0x00. FSM is in IDLE and the FIFO pointers are 0.
- Write: sampled at each rising edge while `uart_in[8]`=1.
  - Accepted if `fifo_count` < `DEPTH`, or if a pop occurs on the same edge.
  - Otherwise the byte is dropped and `overflow` is set to 1.
- Pointers wrap modulo `DEPTH`. `fifo_count` = writes − pops; a simultaneous push and pop leaves it unchanged.
- FSM states: IDLE, START, DATA, STOP. The bit counter is 0..`CLKS_PER_BIT`−1 and the bit index is 0..7.
  - IDLE: `tx`=1. If the FIFO is non-empty: pop into the shift register and go to START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then DATA.
  - DATA: `tx`=shift[0], LSB first. Shift on each bit boundary. After 8 bits, go to STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles. On the final edge:
    - pulse `done_valid` with `done_data`=the frame byte;
    - if the FIFO is non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- `tx` is registered. There are no combinational paths from `uart_in` to any output.
- Reset mid-frame: all outputs go to their reset values immediately, without a clock edge. The FIFO contents and the in-flight byte are discarded, and no `done_valid` is generated for them.

## Timing
- Write at edge N → `fifo_count` increments after N.
- Edge N+1: pop, and `tx` falls.
- Data bit i occupies `tx` from edge N+1+(1+i)·`CLKS_PER_BIT`.
- Stop bit occupies `tx` from edge N+1+9·`CLKS_PER_BIT`.
- `done_valid` is high for the cycle following edge N+1+10·`CLKS_PER_BIT`.
- Frame period is exactly 10·`CLKS_PER_BIT` cycles. Back-to-back frames are contiguous.
- Effective capacity while idle: `DEPTH`+1 bytes (one in the shift register).
- Edge cases:
  - `uart_in[8]` high for consecutive cycles: one byte per cycle.
  - Write on the same edge as a pop from a full FIFO: accepted, and `overflow` stays 0.
- `busy` falls in the same cycle `done_valid` rises when the FIFO is empty.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `DEPTH`=16.

- **Single byte:** write 0x41 at edge N → `tx` shows levels 0,1,0,0,0,0,0,1,0,1, each for 4 cycles, starting after N+1. `done_valid`=1 with `done_data`=0x41 for exactly one cycle after edge N+41. `busy` then returns to 0.
- **Back-to-back:** writes 0x4F, 0x4B, 0x0A on three consecutive edges → 120 contiguous cycles of framing with no idle-high gap between frames. Three `done_valid` pulses, 40 cycles apart, in order 0x4F, 0x4B, 0x0A. `fifo_count` peaks at 2.
- **Overflow:** 18 consecutive writes of 0x00..0x11 from idle → `fifo_count` reaches 16 and `overflow`=1 after the 18th edge. Bytes 0x00..0x10 are transmitted; 0x11 never appears. `overflow` stays 1 until reset.
- **Full plus simultaneous pop:** with the FIFO at 16, write 0x7E on the exact edge where STOP completes and pops → `fifo_count` stays 16, `overflow`=0, and 0x7E is later transmitted last.
- **Reset mid-frame:** drive `reset_n` low during DATA bit 3 with 5 bytes queued → `tx`=1, `fifo_count`=0, `busy`=0 immediately, and no `done_valid` pulse. After release, a write of 0x55 produces a correct frame and `done_data`=0x55.
- **No strobe:** hold `uart_in[8]`=0 for 100 cycles while toggling the data bits → `tx` stays 1, `fifo_count` stays 0, and `done_valid` never asserts.

Source files
------------

// File: rtl/uart_tx_ctrl_if.sv
// uart_tx_ctrl_if: console write strobe toward the transmitter and per-byte completion report back
interface uart_tx_ctrl_if;
    logic [8:0] uart_in;
    logic       done_valid;
    logic [7:0] done_data;
    modport master (output uart_in, input done_valid, done_data);
    modport slave (input uart_in, output done_valid, done_data);
endinterface

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: FIFO-buffered 8N1 console transmitter with per-byte completion pulse
module uart_tx_ctrl #(
    parameter int CLKS_PER_BIT = 4,
    parameter int DEPTH = 16,
    parameter int AW = 4
) (
    input  logic          clock,
    input  logic          reset_n,
    uart_tx_ctrl_if.slave bus,
    output logic          tx,
    output logic          busy,
    output logic          overflow,
    output logic [AW:0]   fifo_count
);
    localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    logic [7:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [1:0] state;
    logic [CW-1:0] cnt;
    logic [2:0] idx;
    logic [7:0] frame;
    logic bit_end, nonempty, pop, push, wr;
    assign bit_end = cnt == LAST;
    assign nonempty = fifo_count != '0;
    assign pop = nonempty && (state == IDLE || (state == STOP && bit_end));
    assign wr = bus.uart_in[8];
    assign push = wr && (fifo_count != (AW+1)'(DEPTH) || pop);
    assign busy = state != IDLE || nonempty;
    always_ff @(posedge clock)
        if (push) mem[wr_ptr] <= bus.uart_in[7:0];
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            state <= IDLE;
            cnt <= '0;
            idx <= '0;
            frame <= '0;
            tx <= 1'b1;
            wr_ptr <= '0;
            rd_ptr <= '0;
            fifo_count <= '0;
            overflow <= 1'b0;
            bus.done_valid <= 1'b0;
            bus.done_data <= '0;
        end else begin
            bus.done_valid <= 1'b0;
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
            overflow <= overflow | (wr & ~push);
            if (pop) frame <= mem[rd_ptr];
            cnt <= (state == IDLE || bit_end) ? '0 : cnt + CW'(1);
            case (state)
                IDLE: if (pop) begin
                    state <= START;
                    tx <= 1'b0;
                end
                START: if (bit_end) begin
                    state <= DATA;
                    idx <= '0;
                    tx <= frame[0];
                end
                DATA: if (bit_end) begin
                    state <= idx == 3'd7 ? STOP : DATA;
                    idx <= idx + 3'd1;
                    tx <= idx == 3'd7 ? 1'b1 : frame[idx + 3'd1];
                end
                STOP: if (bit_end) begin
                    bus.done_valid <= 1'b1;
                    bus.done_data <= frame;
                    state <= pop ? START : IDLE;
                    tx <= ~pop;
                end
            endcase
        end
endmodule
